// File: rtl/matmul_operand_sequencer.sv
// matmul_operand_sequencer: holds two NxN operand matrices, walks every (i, j)
// of the product in row-major order, presents row i of A and column j of B to
// an external scalar-product unit, and stores each returned dot product in C.
module matmul_operand_sequencer #(
    parameter int Nbits = 4,
    parameter int N     = 4,
    parameter int LAT   = 3,
    localparam int AW   = 2 * $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_valid,
    input  logic                 load_sel,
    input  logic [AW-1:0]        load_addr,
    input  logic [Nbits-1:0]     load_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [N*Nbits-1:0]   vecA,
    output logic [N*Nbits-1:0]   vecB,
    input  logic [2*Nbits-1:0]   res_in,
    input  logic [AW-1:0]        rd_addr,
    output logic [2*Nbits-1:0]   rd_data
);

    localparam int IW = $clog2(N);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        STORE,
        DONE
    } state_t;

    state_t            state;
    logic [IW-1:0]     ri;
    logic [IW-1:0]     cj;
    logic [CW-1:0]     cnt;

    logic [Nbits-1:0]   mem_a [N*N];
    logic [Nbits-1:0]   mem_b [N*N];
    logic [2*Nbits-1:0] mem_c [N*N];

    logic [N*Nbits-1:0] row_a;
    logic [N*Nbits-1:0] col_b;
    logic               load_en;
    logic               store_en;

    // Loads are accepted only while no run is using the operand arrays.
    assign load_en  = reset && load_valid && ((state == IDLE) || (state == DONE));
    assign store_en = reset && (state == STORE);

    // Operand storage; not cleared by reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            if (!load_sel) begin
                mem_a[load_addr] <= load_data;
            end else begin
                mem_b[load_addr] <= load_data;
            end
        end
    end

    // Result storage; a reset mid-run leaves already stored entries intact.
    always_ff @(posedge clk) begin
        if (store_en) begin
            mem_c[{ri, cj}] <= res_in;
        end
    end

    // Gather row ri of A and column cj of B into packed vectors.
    always_comb begin
        row_a = '0;
        col_b = '0;
        for (int unsigned k = 0; k < N; k++) begin
            row_a[k*Nbits +: Nbits] = mem_a[{ri, IW'(k)}];
            col_b[k*Nbits +: Nbits] = mem_b[{IW'(k), cj}];
        end
    end

    // Sequencing FSM with registered busy/done/operand outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            ri    <= '0;
            cj    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            vecA  <= '0;
            vecB  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ri    <= '0;
                        cj    <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    vecA  <= row_a;
                    vecB  <= col_b;
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(LAT - 1)) begin
                        state <= STORE;
                    end
                end
                STORE: begin
                    if (cj != IW'(N - 1)) begin
                        cj    <= cj + 1'b1;
                        state <= ISSUE;
                    end else if (ri != IW'(N - 1)) begin
                        cj    <= '0;
                        ri    <= ri + 1'b1;
                        state <= ISSUE;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Registered read port of C, independent of sequencing state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem_c[rd_addr];
        end
    end

endmodule

// File: tb/tb_matmul_operand_sequencer.sv
// Directed bench for matmul_operand_sequencer (N=4, Nbits=4, LAT=3) with a
// zero-latency scalar-product stand-in driving res_in.
module tb_matmul_operand_sequencer;

    localparam int NB  = 4;
    localparam int N   = 4;
    localparam int LAT = 3;
    localparam int AW  = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            load_valid = 1'b0;
    logic            load_sel = 1'b0;
    logic [AW-1:0]   load_addr = '0;
    logic [NB-1:0]   load_data = '0;
    logic            start = 1'b0;
    logic            busy;
    logic            done;
    logic [N*NB-1:0] vecA;
    logic [N*NB-1:0] vecB;
    logic [2*NB-1:0] res_in;
    logic [AW-1:0]   rd_addr = '0;
    logic [2*NB-1:0] rd_data;

    int tests = 0;
    int fails = 0;

    logic [3:0] ma [16];
    logic [3:0] mb [16];
    logic [7:0] expc [16];
    logic [7:0] gold_prev [16];

    matmul_operand_sequencer #(.Nbits(NB), .N(N), .LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_sel   (load_sel),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .vecA       (vecA),
        .vecB       (vecB),
        .res_in     (res_in),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    // Scalar-product unit stand-in: dot product modulo 256.
    always_comb begin
        res_in = '0;
        for (int k = 0; k < N; k++) begin
            res_in = res_in + 8'(vecA[k*NB +: NB]) * 8'(vecB[k*NB +: NB]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] row_of(input int i);
        logic [15:0] v;
        for (int k = 0; k < N; k++) v[k*NB +: NB] = ma[i*N + k];
        return v;
    endfunction

    function automatic logic [15:0] col_of(input int j);
        logic [15:0] v;
        for (int k = 0; k < N; k++) v[k*NB +: NB] = mb[k*N + j];
        return v;
    endfunction

    task automatic set_elem(input logic sel, input int a, input logic [3:0] d);
        load_valid = 1'b1;
        load_sel   = sel;
        load_addr  = 4'(a);
        load_data  = d;
        if (!sel) ma[a] = d; else mb[a] = d;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic golden();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                logic [7:0] s;
                s = '0;
                for (int k = 0; k < N; k++) s = s + 8'(ma[r*N + k]) * 8'(mb[k*N + c]);
                expc[r*N + c] = s;
            end
        end
    endtask

    task automatic read_back(input string name);
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            @(negedge clk);
            check($sformatf("%s_rd[%0d]", name, a), 32'(rd_data), 32'(expc[a]));
        end
    endtask

    // Called at a negedge: that cycle is cycle 0 with start high.
    task automatic run(input string name, input bit noise, input bit chain);
        int idx;
        start = 1'b1;
        for (int c = 1; c <= 81; c++) begin
            @(negedge clk);
            start      = 1'b0;
            load_valid = 1'b0;
            if (noise && c <= 79) begin
                start      = (c % 3 == 0);
                load_valid = (c % 2 == 0);
                load_sel   = c[2];
                load_addr  = 4'(c);
                load_data  = 4'h0;
            end
            check($sformatf("%s_busy_c%0d", name, c), 32'(busy), 32'(c <= 80));
            check($sformatf("%s_done_c%0d", name, c), 32'(done), 32'(c == 81));
            if (c >= 2) begin
                idx = (c - 2) / 5;
                check($sformatf("%s_vecA_c%0d", name, c), 32'(vecA), 32'(row_of(idx / 4)));
                check($sformatf("%s_vecB_c%0d", name, c), 32'(vecB), 32'(col_of(idx % 4)));
            end
            if (chain && c == 81) start = 1'b1;
        end
        if (chain) begin
            @(negedge clk);
            check($sformatf("%s_start_in_done_ignored", name), 32'(busy), 32'd0);
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_vecA", 32'(vecA), 32'd0);
        check("rst_vecB", 32'(vecB), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Identity A, B[r][c] = r*4+c
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                set_elem(1'b0, r*N + c, (r == c) ? 4'd1 : 4'd0);
                set_elem(1'b1, r*N + c, 4'(r*4 + c));
            end
        end
        run("ident", 1'b0, 1'b0);
        for (int a = 0; a < 16; a++) expc[a] = 8'(a);
        read_back("ident");

        // All elements 15: 4*225 = 900 -> 132
        for (int a = 0; a < 16; a++) begin
            set_elem(1'b0, a, 4'd15);
            set_elem(1'b1, a, 4'd15);
        end
        run("max", 1'b0, 1'b0);
        for (int a = 0; a < 16; a++) expc[a] = 8'd132;
        read_back("max");

        // Mixed operands with start pulses and zero loads while busy
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                set_elem(1'b0, r*N + c, 4'(r + c));
                set_elem(1'b1, r*N + c, 4'(r*3 + c*5));
            end
        end
        run("noise", 1'b1, 1'b0);
        golden();
        check("noise_C00_hand", 32'(expc[0]), 32'd42);
        for (int a = 0; a < 16; a++) gold_prev[a] = expc[a];
        read_back("noise");

        // A all 1, B all 2 -> every entry 8; reset after 5 results
        for (int a = 0; a < 16; a++) begin
            set_elem(1'b0, a, 4'd1);
            set_elem(1'b1, a, 4'd2);
        end
        start = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 26) reset = 1'b0;
        end
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_vecA", 32'(vecA), 32'd0);
        check("midrst_vecB", 32'(vecB), 32'd0);
        check("midrst_rd_data", 32'(rd_data), 32'd0);
        reset = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check($sformatf("midrst_quiet_done_%0d", c), 32'(done), 32'd0);
            check($sformatf("midrst_quiet_busy_%0d", c), 32'(busy), 32'd0);
        end
        for (int a = 0; a < 16; a++) expc[a] = (a < 5) ? 8'd8 : gold_prev[a];
        read_back("midrst");

        // Rerun after reset, then start in DONE (ignored) held into IDLE
        run("rerun", 1'b0, 1'b1);
        run("chained", 1'b0, 1'b0);
        for (int a = 0; a < 16; a++) expc[a] = 8'd8;
        read_back("chained");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
